// File: rtl/bs4_pkg.sv
// Shared constants and state encoding for the 4-bit mux-bank shift sequencer.
package bs4_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int AMT_W_DEF = 2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic MODE_LOG  = 1'b0;
  localparam logic MODE_ROT  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bs4_step.sv
// One-position shift/rotate of r, built as per-bit 2:1 mux pairs (fill mux, then direction mux).
module bs4_step
  import bs4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] r,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] r_next
);
  logic [WIDTH-1:0] lft, rgt;

  // End bits take either zero or the wrapped-around bit, selected by mode.
  assign lft[0]       = (mode == MODE_ROT) ? r[WIDTH-1] : 1'b0;
  assign rgt[WIDTH-1] = (mode == MODE_ROT) ? r[0]       : 1'b0;

  for (genvar i = 1; i < WIDTH; i++) begin : g_lft
    assign lft[i] = r[i-1];
  end
  for (genvar i = 0; i < WIDTH-1; i++) begin : g_rgt
    assign rgt[i] = r[i+1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_dir
    assign r_next[i] = (dir == DIR_RIGHT) ? rgt[i] : lft[i];
  end
endmodule

// File: rtl/bs4_shift_seq.sv
// Start/busy/done sequencer that shifts the operand register one bit per clock via bs4_step.
module bs4_shift_seq
  import bs4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             mux_sel
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_step;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q, mode_q;

  bs4_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .dir    (dir_q),
    .mode   (mode_q),
    .r_next (r_step)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (amt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt_q == AMT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
      mode_q  <= MODE_LOG;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          r_q    <= din;
          cnt_q  <= amt;
          dir_q  <= dir;
          mode_q <= mode;
        end
        S_SHIFT: begin
          r_q <= r_step;
          // Guarded so the counter can never wrap below zero.
          if (cnt_q != '0) cnt_q <= cnt_q - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign mux_sel = (state_q == S_SHIFT);
  assign dout    = r_q;
endmodule
